// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage load/store unit.
// Holds the LoadType/StoreType codes produced by the control decoder, the
// unit's state encoding, and the alignment check used by the top level.
package mem_access_unit_pkg;

  localparam logic [2:0] LoadByte      = 3'b000;
  localparam logic [2:0] LoadByteU     = 3'b001;
  localparam logic [2:0] LoadHalfWord  = 3'b010;
  localparam logic [2:0] LoadHalfWordU = 3'b011;
  localparam logic [2:0] LoadWord      = 3'b100;

  localparam logic [1:0] StoreByte     = 2'b00;
  localparam logic [1:0] StoreHalfWord = 2'b01;
  localparam logic [1:0] StoreWord     = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Access size: 0 = byte, 1 = half, 2 = word. Unused codes behave as word.
  function automatic logic [1:0] access_size(input logic       is_wr,
                                             input logic [2:0] ltype,
                                             input logic [1:0] stype);
    logic [1:0] sz;
    sz = 2'd2;
    if (is_wr) begin
      if (stype == StoreByte)          sz = 2'd0;
      else if (stype == StoreHalfWord) sz = 2'd1;
    end else begin
      if (ltype == LoadByte || ltype == LoadByteU)              sz = 2'd0;
      else if (ltype == LoadHalfWord || ltype == LoadHalfWordU) sz = 2'd1;
    end
    return sz;
  endfunction

  function automatic logic is_aligned(input logic [1:0] sz, input logic [1:0] lane);
    logic ok;
    case (sz)
      2'd0:    ok = 1'b1;
      2'd1:    ok = ~lane[0];
      default: ok = (lane == 2'b00);
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Combinational load data extraction.
// Picks the addressed byte/half out of a little-endian bus word and sign- or
// zero-extends it according to LoadType; words pass straight through.
// Ports: rdata (bus word), lane (addr[1:0]), load_type, result (32-bit).
module mem_access_unit_load_extend
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  lane,
  input  logic [2:0]  load_type,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[8*lane +: 8];
    half_sel = lane[1] ? rdata[31:16] : rdata[15:0];
    case (load_type)
      LoadByte:      result = {{24{byte_sel[7]}}, byte_sel};
      LoadByteU:     result = {24'h0, byte_sel};
      LoadHalfWord:  result = {{16{half_sel[15]}}, half_sel};
      LoadHalfWordU: result = {16'h0, half_sel};
      default:       result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit.
// Turns registered MemRead/MemWrite controls into one req/ack transaction on
// the data bus, steers store bytes onto lanes, extends load data, and stalls
// the pipeline while the access is outstanding. Misaligned accesses are
// dropped with a misalign pulse; a bus that never acks gives a bus_error pulse.
// Ports:
//   clk, reset (sync, active low)
//   valid, MemRead, MemWrite, LoadType, StoreType, addr, wdata : EX/MEM inputs
//   mem_req, mem_we, mem_addr, mem_be, mem_wdata, mem_ack, mem_rdata : bus
//   stall, load_data, load_valid, misalign, bus_error : pipeline side
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  LoadType,
  input  logic [1:0]  StoreType,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        misalign,
  output logic        bus_error
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  lane_q, lane_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  ltype_q, ltype_d;
  logic [31:0] load_data_q, load_data_d;
  logic        misalign_q, misalign_d;
  logic        bus_error_q, bus_error_d;

  logic        start, is_wr, aligned;
  logic [1:0]  sz;
  logic [3:0]  be_new;
  logic [31:0] wdata_new;
  logic [31:0] ext_data;

  // Write wins when both MemRead and MemWrite are set.
  assign start   = valid & (MemRead | MemWrite);
  assign is_wr   = MemWrite;
  assign sz      = access_size(is_wr, LoadType, StoreType);
  assign aligned = is_aligned(sz, addr[1:0]);

  // Lane steering: data replicated across lanes, enables select the target.
  // Loads use the same enable pattern so the bus sees the accessed bytes.
  always_comb begin
    case (sz)
      2'd0: begin
        be_new    = 4'b0001 << addr[1:0];
        wdata_new = {4{wdata[7:0]}};
      end
      2'd1: begin
        be_new    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_new = {2{wdata[15:0]}};
      end
      default: begin
        be_new    = 4'b1111;
        wdata_new = wdata;
      end
    endcase
    if (!is_wr) wdata_new = 32'h0;
  end

  mem_access_unit_load_extend u_load_extend (
    .rdata     (mem_rdata),
    .lane      (lane_q),
    .load_type (ltype_q),
    .result    (ext_data)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= 32'h0;
      lane_q      <= 2'b00;
      be_q        <= 4'h0;
      wdata_q     <= 32'h0;
      ltype_q     <= 3'b000;
      load_data_q <= 32'h0;
      misalign_q  <= 1'b0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      lane_q      <= lane_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      ltype_q     <= ltype_d;
      load_data_q <= load_data_d;
      misalign_q  <= misalign_d;
      bus_error_q <= bus_error_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    lane_d      = lane_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    ltype_d     = ltype_q;
    load_data_d = load_data_q;
    misalign_d  = 1'b0;
    bus_error_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (!aligned) begin
            misalign_d = 1'b1;
          end else begin
            state_d = REQ;
            cnt_d   = '0;
            we_d    = is_wr;
            addr_d  = {addr[31:2], 2'b00};
            lane_d  = addr[1:0];
            be_d    = be_new;
            wdata_d = wdata_new;
            ltype_d = LoadType;
          end
        end
      end
      REQ: begin
        if (mem_ack) begin
          state_d = DONE;
          if (!we_q) load_data_d = ext_data;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d     = IDLE;
          bus_error_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    mem_req    = (state_q == REQ);
    mem_we     = we_q;
    mem_addr   = addr_q;
    mem_be     = be_q;
    mem_wdata  = wdata_q;
    load_data  = load_data_q;
    load_valid = (state_q == DONE) & ~we_q;
    misalign   = misalign_q;
    bus_error  = bus_error_q;
    // Low in DONE so the pipeline advances on the DONE edge.
    stall      = ((state_q == IDLE) & start & aligned) | (state_q == REQ);
  end

endmodule
